// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM that steps the CPU datapath through fetch, decode, execute,
// memory and writeback. Also counts retired instructions, times out stalled handshakes and halts.
module cpu_sequencer #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   input  logic             reg_write,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             mem_to_reg,
   input  logic             branch,
   input  logic             jump,
   input  logic             jump_reg,
   input  logic             illegal,
   input  logic             branch_taken,
   output logic             alu_en,
   output logic             dmem_req,
   input  logic             dmem_ready,
   output logic             dmem_we,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic [CNT_W-1:0] retire_count,
   output logic [2:0]       state,
   output logic             halted,
   output logic             err_timeout
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd7
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_wait;
   logic             r_fetchBusy;
   logic [1:0]       r_pcSel;
   logic [1:0]       w_pcSelExec;
   logic             r_errTimeout;
   logic [CNT_W-1:0] r_retire;
   logic             w_stall;
   logic             w_timeout;
   logic             w_flowConflict;

   // A fetch that has been issued keeps requesting even if run drops meanwhile.
   assign imem_req = (r_state == S_FETCH) && (run || r_fetchBusy);
   assign dmem_req = (r_state == S_MEM);

   assign w_stall        = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
   assign w_timeout      = w_stall && (r_wait == 8'(TIMEOUT - 1));
   assign w_flowConflict = (branch && jump) || (branch && jump_reg) || (jump && jump_reg);

   assign w_pcSelExec = jump_reg                      ? 2'd2 :
                        (jump || (branch && branch_taken)) ? 2'd1 : 2'd0;

   assign pc_sel       = (r_state == S_EXECUTE) ? w_pcSelExec : r_pcSel;
   assign state        = r_state;
   assign retire_count = r_retire;
   assign err_timeout  = r_errTimeout;

   always_comb begin
      w_next  = r_state;
      ir_we   = 1'b0;
      alu_en  = 1'b0;
      dmem_we = 1'b0;
      rf_we   = 1'b0;
      wb_sel  = 2'd0;
      pc_we   = 1'b0;
      halted  = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (imem_req && imem_ready) begin
               ir_we  = 1'b1;
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (illegal || (mem_read && mem_write) || w_flowConflict) w_next = S_HALT;
            else w_next = S_EXECUTE;
         end
         S_EXECUTE: begin
            alu_en = 1'b1;
            if (mem_read || mem_write) w_next = S_MEM;
            else if (reg_write) w_next = S_WB;
            else begin
               pc_we  = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_MEM: begin
            dmem_we = mem_write;
            if (dmem_ready) begin
               if (mem_read) w_next = S_WB;
               else begin
                  pc_we  = 1'b1;
                  w_next = S_FETCH;
               end
            end
         end
         S_WB: begin
            rf_we  = reg_write;
            pc_we  = 1'b1;
            w_next = S_FETCH;
            if (reg_write) begin
               if (jump || jump_reg) wb_sel = 2'd2;
               else if (mem_to_reg) wb_sel = 2'd1;
            end
         end
         S_HALT:  halted = 1'b1;
         default: w_next = S_HALT;
      endcase
      if (w_timeout) w_next = S_HALT;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_FETCH;
         r_wait       <= 8'd0;
         r_fetchBusy  <= 1'b0;
         r_pcSel      <= 2'd0;
         r_errTimeout <= 1'b0;
         r_retire     <= '0;
      end else begin
         r_state     <= w_next;
         r_fetchBusy <= imem_req && !imem_ready && !w_timeout;
         if (w_stall && !w_timeout) r_wait <= r_wait + 8'd1;
         else r_wait <= 8'd0;
         if (w_timeout) r_errTimeout <= 1'b1;
         if (r_state == S_EXECUTE) r_pcSel <= w_pcSelExec;
         if (pc_we) r_retire <= r_retire + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a transaction-level model expands each instruction
// into its expected per-cycle trace, and one compare process checks the DUT against it.
module tb_cpu_sequencer;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic rw, mr, mw, m2r, br, j, jr, ill;
   } ctrl_t;

   typedef struct packed {
      logic [2:0]       st;
      logic             iReq, irWe, alu, dReq, dWe, rfWe;
      logic [1:0]       wbSel;
      logic             pcWe;
      logic [1:0]       pcSel;
      logic             hlt, err;
      logic [CNT_W-1:0] ret;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run = 1'b0;
   logic imem_ready = 1'b0;
   logic dmem_ready = 1'b0;
   logic branchTaken = 1'b0;
   ctrl_t ctl = '0;

   logic             reg_write, mem_read, mem_write, mem_to_reg, branch, jump, jump_reg, illegal;
   logic             imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, halted, err_timeout;
   logic [1:0]       wb_sel, pc_sel;
   logic [CNT_W-1:0] retire_count;
   logic [2:0]       state;

   exp_t             expQ[$];
   exp_t             cmpE;
   logic [CNT_W-1:0] expRetire = '0;
   logic             expErr = 1'b0;
   int               checks = 0;
   int               errors = 0;
   int               cycleNo = 0;
   int               n;

   assign reg_write  = ctl.rw;
   assign mem_read   = ctl.mr;
   assign mem_write  = ctl.mw;
   assign mem_to_reg = ctl.m2r;
   assign branch     = ctl.br;
   assign jump       = ctl.j;
   assign jump_reg   = ctl.jr;
   assign illegal    = ctl.ill;

   cpu_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jump_reg(jump_reg),
      .illegal(illegal), .branch_taken(branchTaken), .alu_en(alu_en),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we),
      .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
      .retire_count(retire_count), .state(state), .halted(halted),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cycleNo, got, want);
      end
   endtask

   // Every expected cycle is compared on the falling edge, away from the register updates.
   always @(negedge clk) begin
      cycleNo++;
      if (expQ.size() > 0) begin
         cmpE = expQ.pop_front();
         checkOutput("state", 32'(state), 32'(cmpE.st));
         checkOutput("imem_req", 32'(imem_req), 32'(cmpE.iReq));
         checkOutput("ir_we", 32'(ir_we), 32'(cmpE.irWe));
         checkOutput("alu_en", 32'(alu_en), 32'(cmpE.alu));
         checkOutput("dmem_req", 32'(dmem_req), 32'(cmpE.dReq));
         checkOutput("dmem_we", 32'(dmem_we), 32'(cmpE.dWe));
         checkOutput("rf_we", 32'(rf_we), 32'(cmpE.rfWe));
         checkOutput("wb_sel", 32'(wb_sel), 32'(cmpE.wbSel));
         checkOutput("pc_we", 32'(pc_we), 32'(cmpE.pcWe));
         checkOutput("halted", 32'(halted), 32'(cmpE.hlt));
         checkOutput("err_timeout", 32'(err_timeout), 32'(cmpE.err));
         checkOutput("retire_count", 32'(retire_count), 32'(cmpE.ret));
         if (cmpE.pcWe) checkOutput("pc_sel", 32'(pc_sel), 32'(cmpE.pcSel));
      end
   end

   // RV32I opcode classes as the decoder would present them.
   function automatic ctrl_t decodeWord(input logic [31:0] w);
      ctrl_t c;
      c = '0;
      case (w[6:0])
         7'h33, 7'h13, 7'h37, 7'h17: c.rw = 1'b1;
         7'h03: begin c.rw = 1'b1; c.mr = 1'b1; c.m2r = 1'b1; end
         7'h23: c.mw = 1'b1;
         7'h63: c.br = 1'b1;
         7'h6f: begin c.rw = 1'b1; c.j = 1'b1; end
         7'h67: begin c.rw = 1'b1; c.jr = 1'b1; end
         default: c.ill = 1'b1;
      endcase
      return c;
   endfunction

   function automatic exp_t base(input logic [2:0] st);
      exp_t e;
      e     = '0;
      e.st  = st;
      e.err = expErr;
      e.ret = expRetire;
      return e;
   endfunction

   task automatic step(input exp_t e, input logic ir, input logic dr);
      imem_ready = ir;
      dmem_ready = dr;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic haltCycles(input int cnt);
      exp_t e;
      run = 1'b1;
      for (int i = 0; i < cnt; i++) begin
         e     = base(3'd7);
         e.hlt = 1'b1;
         step(e, 1'b1, 1'b1);
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      run   = 1'b0;
      ctl   = '0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      expRetire = '0;
      expErr    = 1'b0;
      rst_n     = 1'b1;
      step(base(3'd0), 1'b0, 1'b0);
   endtask

   // Expands one instruction into its expected trace. A delay of -1 means the ready never comes;
   // memAbort >= 0 stops generation after that many stalled MEM cycles.
   task automatic applyStimulus(input ctrl_t c, input logic taken, input int iDelay, input int dDelay,
                                input int memAbort, input bit dropRun, output int cycles);
      exp_t       e;
      logic [1:0] sel;
      int         k;
      cycles      = 0;
      ctl         = c;
      branchTaken = taken;
      run         = 1'b1;
      k           = 0;
      forever begin
         e      = base(3'd0);
         e.iReq = 1'b1;
         if (iDelay >= 0 && k == iDelay) begin
            e.irWe = 1'b1;
            step(e, 1'b1, 1'b1);
            cycles++;
            break;
         end
         if (k == TIMEOUT - 1) begin
            step(e, 1'b0, 1'b1);
            cycles++;
            expErr = 1'b1;
            haltCycles(3);
            return;
         end
         step(e, 1'b0, 1'b1);
         cycles++;
         if (dropRun) run = 1'b0;
         k++;
      end
      step(base(3'd1), 1'b1, 1'b1);
      cycles++;
      if (c.ill || (c.mr && c.mw) || (int'(c.br) + int'(c.j) + int'(c.jr) > 1)) begin
         haltCycles(3);
         return;
      end
      sel   = c.jr ? 2'd2 : ((c.j || (c.br && taken)) ? 2'd1 : 2'd0);
      e     = base(3'd2);
      e.alu = 1'b1;
      if (!c.mr && !c.mw && !c.rw) begin
         e.pcWe  = 1'b1;
         e.pcSel = sel;
         step(e, 1'b1, 1'b1);
         cycles++;
         expRetire++;
         return;
      end
      step(e, 1'b1, 1'b1);
      cycles++;
      if (c.mr || c.mw) begin
         k = 0;
         forever begin
            if (memAbort >= 0 && k == memAbort) return;
            e      = base(3'd3);
            e.dReq = 1'b1;
            e.dWe  = c.mw;
            if (dDelay >= 0 && k == dDelay) begin
               if (!c.mr) begin
                  e.pcWe  = 1'b1;
                  e.pcSel = sel;
               end
               step(e, 1'b1, 1'b1);
               cycles++;
               if (!c.mr) begin
                  expRetire++;
                  return;
               end
               break;
            end
            if (k == TIMEOUT - 1) begin
               step(e, 1'b1, 1'b0);
               cycles++;
               expErr = 1'b1;
               haltCycles(3);
               return;
            end
            step(e, 1'b1, 1'b0);
            cycles++;
            k++;
         end
      end
      e       = base(3'd4);
      e.rfWe  = c.rw;
      e.wbSel = c.rw ? ((c.j || c.jr) ? 2'd2 : (c.m2r ? 2'd1 : 2'd0)) : 2'd0;
      e.pcWe  = 1'b1;
      e.pcSel = sel;
      step(e, 1'b1, 1'b1);
      cycles++;
      expRetire++;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at cycle=%0d", cycleNo);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      ctrl_t cx;
      exp_t  e;
      doReset();
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_retire", 32'(retire_count), 32'd0);

      applyStimulus(decodeWord(32'h007302b3), 1'b0, 0, 0, -1, 1'b0, n);
      checkOutput("alu_latency", n, 4);
      checkOutput("retire_after_alu", 32'(retire_count), 32'd1);
      applyStimulus(decodeWord(32'h0081a283), 1'b0, 0, 3, -1, 1'b0, n);
      checkOutput("load_latency", n, 8);
      applyStimulus(decodeWord(32'h0040a623), 1'b0, 0, 0, -1, 1'b0, n);
      checkOutput("store_latency", n, 4);
      applyStimulus(decodeWord(32'h00208263), 1'b1, 0, 0, -1, 1'b0, n);
      checkOutput("beq_taken_latency", n, 3);
      applyStimulus(decodeWord(32'h00208263), 1'b0, 0, 0, -1, 1'b0, n);
      applyStimulus(decodeWord(32'h006200e7), 1'b0, 0, 0, -1, 1'b0, n);
      checkOutput("jalr_latency", n, 4);
      applyStimulus(decodeWord(32'h008000ef), 1'b0, 0, 0, -1, 1'b0, n);

      // Fetch issued with run high, then run drops: the fetch must still complete.
      applyStimulus(decodeWord(32'h007302b3), 1'b0, 2, 0, -1, 1'b1, n);
      run = 1'b0;
      step(base(3'd0), 1'b1, 1'b1);
      step(base(3'd0), 1'b1, 1'b1);

      // Longest stalls that must not time out.
      applyStimulus(decodeWord(32'h007302b3), 1'b0, TIMEOUT - 1, 0, -1, 1'b0, n);
      applyStimulus(decodeWord(32'h0081a283), 1'b0, 0, TIMEOUT - 1, -1, 1'b0, n);
      checkOutput("retire_ten", 32'(retire_count), 32'd10);
      for (int i = 0; i < 6; i++) applyStimulus(decodeWord(32'h00208263), 1'b0, 0, 0, -1, 1'b0, n);
      checkOutput("retire_wrap", 32'(retire_count), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(decodeWord(32'h00208263), 1'b1, 0, 0, -1, 1'b0, n);

      applyStimulus(decodeWord(32'h00000000), 1'b0, 0, 0, -1, 1'b0, n);
      checkOutput("illegal_halted", 32'(halted), 32'd1);
      checkOutput("illegal_retire_frozen", 32'(retire_count), 32'd3);

      doReset();
      cx = '0; cx.mr = 1'b1; cx.mw = 1'b1; cx.rw = 1'b1;
      applyStimulus(cx, 1'b0, 0, 0, -1, 1'b0, n);
      doReset();
      cx = '0; cx.br = 1'b1; cx.j = 1'b1;
      applyStimulus(cx, 1'b1, 0, 0, -1, 1'b0, n);
      doReset();

      applyStimulus(decodeWord(32'h007302b3), 1'b0, -1, 0, -1, 1'b0, n);
      checkOutput("imem_timeout_state", 32'(state), 32'd7);
      checkOutput("imem_timeout_err", 32'(err_timeout), 32'd1);
      checkOutput("imem_timeout_req", 32'(imem_req), 32'd0);
      doReset();
      checkOutput("post_timeout_err", 32'(err_timeout), 32'd0);

      applyStimulus(decodeWord(32'h0081a283), 1'b0, 0, -1, -1, 1'b0, n);
      checkOutput("dmem_timeout_err", 32'(err_timeout), 32'd1);
      doReset();

      // Reset asserted mid-handshake: the request must drop right after it is sampled.
      applyStimulus(decodeWord(32'h0081a283), 1'b0, 0, -1, 2, 1'b0, n);
      rst_n = 1'b0;
      run   = 1'b0;
      e      = base(3'd3);
      e.dReq = 1'b1;
      step(e, 1'b1, 1'b0);
      expRetire = '0;
      expErr    = 1'b0;
      step(base(3'd0), 1'b0, 1'b1);
      checkOutput("reset_mid_mem_req", 32'(dmem_req), 32'd0);
      rst_n = 1'b1;
      step(base(3'd0), 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM that sequences the CPU datapath around decoder_stage. It drives instruction fetch, latches the instruction register, enables the ALU, issues data-memory requests, writes back to the register file, and updates the PC, one instruction at a time. It consumes the decoder's control outputs plus memory ready handshakes. It also provides retire counting, wait-timeout detection and a sticky halt on illegal or stuck conditions.

Parameters:
CNT_W, 32, width of retire_count; wraps modulo 2^CNT_W.
TIMEOUT, 16, maximum cycles waiting on imem_ready or dmem_ready before the block halts with an error; legal range 1 to 255.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
run  in  1  permits starting a new fetch.
imem_req  out  1  instruction fetch request; held until imem_ready.
imem_ready  in  1  instruction word valid this cycle.
ir_we  out  1  one-cycle pulse that loads the instruction register.
reg_write, mem_read, mem_write, mem_to_reg, branch, jump, jump_reg  in  1 each  decoder control outputs; stable from DECODE until the instruction ends.
illegal  in  1  decoder flags an unrecognised opcode.
branch_taken  in  1  ALU compare result; sampled in EXECUTE.
alu_en  out  1  ALU operand/result register enable.
dmem_req  out  1  data memory request; held until dmem_ready.
dmem_we  out  1  equals mem_write while dmem_req is high; 0 otherwise.
rf_we  out  1  register file write enable.
wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
pc_we  out  1  PC update strobe; asserted exactly once per retired instruction.
pc_sel  out  2  next PC source: 0 = PC+4, 1 = PC+imm, 2 = rs1+imm (LSB cleared by datapath).
retire_count  out  CNT_W  number of retired instructions.
state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=7.
halted  out  1  high in HALT.
err_timeout  out  1  sticky; set when the block halts on a timeout.

Behaviour:
- Reset, synchronous, while rst_n=0 at a clk edge:
  - state=FETCH.
  - All outputs 0; retire_count=0; wait counter=0; err_timeout=0.
  - Reset has priority in every state, including mid-handshake. Any outstanding req drops the cycle after reset is sampled.
- FETCH:
  - If run=0: idle with imem_req=0.
  - If run=1: imem_req=1.
  - When imem_req and imem_ready are both high: ir_we=1 that cycle, next state DECODE.
  - run only gates entry into a fetch. A fetch already issued completes even if run drops.
- DECODE, 1 cycle:
  - Go to HALT if any of these hold: illegal=1; mem_read & mem_write; more than one of branch, jump, jump_reg is set.
  - Otherwise go to EXECUTE.
- EXECUTE, 1 cycle, alu_en=1:
  - pc_sel is computed here and held through the end of the instruction:
    - 2 if jump_reg.
    - 1 if jump, or branch & branch_taken.
    - 0 otherwise.
  - Next state: MEM if mem_read|mem_write; else WB if reg_write; else FETCH with pc_we=1 this cycle (branch / store-less no-write cases).
- MEM:
  - dmem_req=1 and dmem_we=mem_write until dmem_ready.
  - On ready: go to WB if mem_read; else (store) go to FETCH with pc_we=1 in the ready cycle.
- WB, 1 cycle:
  - rf_we=reg_write and pc_we=1; next state FETCH.
  - wb_sel: 2 if jump|jump_reg; else 1 if mem_to_reg; else 0.
  - wb_sel is valid while rf_we=1 and is 0 otherwise.
- Instruction latency with zero-wait memories:
  - ALU op: 4 cycles (F, D, E, W).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL/JALR: 4 cycles.
- retire_count increments on every pc_we and wraps to 0 after all-ones.
- Wait counter:
  - Counts consecutive cycles with imem_req=1 & !imem_ready, or dmem_req=1 & !dmem_ready; clears when the handshake completes.
  - Reaching TIMEOUT: next state HALT, err_timeout=1, requests drop.
- HALT:
  - Absorbing until reset.
  - All strobes 0; halted=1; retire_count frozen.
- imem_ready or dmem_ready asserted while the matching req is low is ignored.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then run=1, imem_ready=1, instruction 0x007302b3 (reg_write=1) -> states 0,1,2,4; rf_we=1 and wb_sel=0 in cycle 4; pc_we=1, pc_sel=0; retire_count=1.
2. Load 0x0081a283 with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with wb_sel=1; total 8 cycles; retire_count +1.
3. Store 0x0040a623, dmem_ready immediate -> dmem_we=1 for 1 cycle; pc_we in the MEM cycle; rf_we never 1.
4. beq 0x00208263 with branch_taken=1 -> pc_we in EXECUTE with pc_sel=1 after 3 cycles. Repeat with branch_taken=0 -> pc_sel=0. jalr 0x006200e7 -> pc_sel=2, wb_sel=2, rf_we=1.
5. TIMEOUT=16 with imem_ready held 0 -> after 16 request cycles: state=7, halted=1, err_timeout=1, imem_req=0; stays halted until rst_n=0, after which state=0 and err_timeout=0.
6. illegal=1 in DECODE (instruction 0x00000000) -> HALT the next cycle, retire_count unchanged. Separately: preload retire_count to all-ones via 2^CNT_W retires with CNT_W=4 -> wraps to 0. Reset asserted during MEM -> dmem_req=0 the next cycle.
